keypad_press_driver: RTL and testbench

//  Transmit side of the 3x4 keypad interface consumed by the combinational lock.

---
 rtl/keypad_press_driver.sv | 150 +++++++++++++++
 tb/tb_keypad_press_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_press_driver.sv
// Keypad press driver: turns handshaked key codes into timed one-hot h/v presses for the lock.
// Optional KEYPAD_ERR_EN adds key_err and skips the press phase for invalid codes (12-15).
module keypad_press_driver #(
    parameter int unsigned PRESS_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [1:3] h,
    output logic [1:4] v,
    output logic       busy,
`ifdef KEYPAD_ERR_EN
    output logic       key_err,
`endif
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:3]       h_q, h_d;
    logic [1:4]       v_q, v_d;
    logic             handshake;
    logic             invalid_code;
    logic             phase_last;

    // Returns {v, h} for a key code; unmapped codes give all zeros.
    function automatic logic [6:0] keymap(input logic [3:0] code);
        logic [6:0] vh;
        unique case (code)
            4'd1:    vh = {4'b1000, 3'b100};
            4'd2:    vh = {4'b1000, 3'b010};
            4'd3:    vh = {4'b1000, 3'b001};
            4'd4:    vh = {4'b0100, 3'b100};
            4'd5:    vh = {4'b0100, 3'b010};
            4'd6:    vh = {4'b0100, 3'b001};
            4'd7:    vh = {4'b0010, 3'b100};
            4'd8:    vh = {4'b0010, 3'b010};
            4'd9:    vh = {4'b0010, 3'b001};
            4'd10:   vh = {4'b0001, 3'b100};
            4'd0:    vh = {4'b0001, 3'b010};
            4'd11:   vh = {4'b0001, 3'b001};
            default: vh = 7'b0;
        endcase
        return vh;
    endfunction

    assign handshake  = key_valid && (state_q == S_IDLE);
    assign phase_last = (cnt_q == CNT_ZERO);

`ifdef KEYPAD_ERR_EN
    assign invalid_code = (key_code > 4'd11);
`else
    assign invalid_code = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        v_d     = v_q;
        unique case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    if (invalid_code) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                        h_d     = 3'b000;
                        v_d     = 4'b0000;
                    end else begin
                        state_d    = S_PRESS;
                        cnt_d      = PRESS_LOAD;
                        {v_d, h_d} = keymap(key_code);
                    end
                end
            end
            S_PRESS: begin
                if (phase_last) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                    h_d     = 3'b000;
                    v_d     = 4'b0000;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (phase_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                h_d     = 3'b000;
                v_d     = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            h_q     <= 3'b000;
            v_q     <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

`ifdef KEYPAD_ERR_EN
    logic err_q;

    // Pulses during the first (gap) cycle of an invalid-code transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= handshake && invalid_code;
        end
    end

    assign key_err = err_q;
`endif

    assign key_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_PRESS) || (state_q == S_GAP);
    assign done      = (state_q == S_GAP) && phase_last;
    assign h         = h_q;
    assign v         = v_q;

endmodule

// File: tb/tb_keypad_press_driver.sv
// Scoreboard bench for keypad_press_driver: two instances (1/1 and 3/2 timing), randomized keys.
module tb_keypad_press_driver;

    typedef struct packed {
        logic [3:0] v;
        logic [2:0] h;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_main = 1'b0;
    logic rst_test = 1'b1;
    logic rst_n;
    bit   go = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   finished = 0;
    int   seq[4] = '{1, 1, 0, 5};

    // {v, h, busy, key_ready, done, key_err} while idle / in reset
    localparam logic [10:0] IDLE_OBS = 11'b0000_000_0_1_0_0;

    assign rst_n = rst_main & rst_test;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%b want=%b", name, $time, act, exp);
        end
    endtask

    // Keypad geometry: digits 1-9 fill rows top-down, left-right; bottom row is *, 0, #.
    function automatic exp_t model(input int c);
        exp_t e;
        int   row;
        int   col;
        e   = '0;
        row = -1;
        col = 0;
        if (c >= 1 && c <= 9) begin
            row = (c - 1) / 3;
            col = (c - 1) % 3;
        end else if (c == 10) begin
            row = 3; col = 0;
        end else if (c == 0) begin
            row = 3; col = 1;
        end else if (c == 11) begin
            row = 3; col = 2;
        end
        if (row >= 0) begin
            e.v = 4'b1000 >> row;
            e.h = 3'b100 >> col;
        end
`ifdef KEYPAD_ERR_EN
        e.err = (c >= 12);
`endif
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned P = (g == 0) ? 1 : 3;
        localparam int unsigned G = (g == 0) ? 1 : 2;

        logic       kv;
        logic [3:0] kc;
        logic       kr;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:3] h;
        logic [1:4] v;
        exp_t       q[$];
        bit         drv_done = 1'b0;

        keypad_press_driver #(
            .PRESS_CYCLES(P),
            .GAP_CYCLES  (G),
            .CNT_W       (8)
        ) dut (
            .clk      (clk),
            .reset    (rst_n),
            .key_valid(kv),
            .key_code (kc),
            .key_ready(kr),
            .h        (h),
            .v        (v),
            .busy     (busy),
`ifdef KEYPAD_ERR_EN
            .key_err  (err),
`endif
            .done     (done)
        );

`ifndef KEYPAD_ERR_EN
        assign err = 1'b0;
`endif

        // Driver: holds key_valid and scrambles key_code while the DUT is busy.
        initial begin
            kv = 1'b0;
            kc = 4'd0;
            wait (go);
            for (int n = 0; n < 80; n++) begin
                int  c;
                int  idle;
                int  waited;
                bit  taken;
                if (n < 12) c = n;
                else if (n < 16) c = seq[n-12];
                else if ($urandom_range(0, 7) == 0) c = $urandom_range(12, 15);
                else c = $urandom_range(0, 11);
                idle = (n < 16) ? 0 : $urandom_range(0, 2);
                repeat (idle) begin
                    @(negedge clk);
                    kv = 1'b0;
                    kc = 4'($urandom);
                end
                waited = 0;
                taken  = 1'b0;
                while (!taken && waited <= 40) begin
                    @(negedge clk);
                    kv = 1'b1;
                    if (kr) begin
                        kc    = 4'(c);
                        taken = 1'b1;
                    end else begin
                        kc = 4'($urandom);
                        waited++;
                    end
                end
                if (taken) begin
                    @(posedge clk);
                    q.push_back(model(c));
                end else begin
                    check("ready_timeout", {10'b0, kr}, 11'd1);
                end
            end
            @(negedge clk);
            kv = 1'b0;
            drv_done = 1'b1;
        end

        // Monitor: every busy episode pops one expected key and walks its press/gap timeline.
        initial begin
            @(negedge clk);
            check("reset", {v, h, busy, kr, done, err}, IDLE_OBS);
            wait (rst_n == 1'b1);
            while (!(drv_done && q.size() == 0)) begin
                @(negedge clk);
                if (!busy) begin
                    if (q.size() != 0) begin
                        check("start", {10'b0, busy}, 11'd1);
                        void'(q.pop_front());
                    end else begin
                        check("idle", {v, h, busy, kr, done, err}, IDLE_OBS);
                    end
                end else if (q.size() == 0) begin
                    check("spurious", {v, h, busy, kr, done, err}, IDLE_OBS);
                end else begin
                    exp_t e;
                    int   p;
                    e = q.pop_front();
                    p = e.err ? 0 : int'(P);
                    for (int i = 0; i < p; i++) begin
                        if (i > 0) @(negedge clk);
                        check("press", {v, h, busy, kr, done, err}, {e.v, e.h, 4'b1000});
                    end
                    for (int i = 0; i < int'(G); i++) begin
                        if (p > 0 || i > 0) @(negedge clk);
                        check("gap", {v, h, busy, kr, done, err},
                              {7'b0, 1'b1, 1'b0, (i == int'(G) - 1), (e.err && i == 0)});
                    end
                end
            end
            finished++;
        end

        if (g == 1) begin : g_rst
            // Asynchronous reset in the middle of a long press of '6'.
            initial begin
                wait (finished >= 2);
                @(negedge clk);
                kv = 1'b1;
                kc = 4'd6;
                @(posedge clk);
                #1 kv = 1'b0;
                @(negedge clk);
                check("pre_reset_6", {v, h, busy, kr, done, err}, {4'b0100, 3'b001, 4'b1000});
                #2 rst_test = 1'b0;
                #1 check("async_reset", {v, h, busy, kr, done, err}, IDLE_OBS);
                @(negedge clk);
                rst_test = 1'b1;
                @(negedge clk);
                check("after_reset", {v, h, busy, kr, done, err}, IDLE_OBS);
                finished++;
            end
        end
    end

    initial begin
        rst_main = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_main = 1'b1;
        go = 1'b1;
        fork
            wait (finished == 3);
            repeat (20000) @(posedge clk);
        join_any
        disable fork;
        if (finished != 3) begin
            bad++;
            total++;
            $display("FAIL run_timeout: finished=%0d want=3", finished);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
